// File: rtl/sseg_scan_mux.sv
// ---------------------------------------------------------------------------
// sseg_scan_mux
//
// Multiplexed seven-segment scan driver for NUM_DIGITS common-anode digits.
// Each digit gets a time slot of SLOT_TICKS clocks, scanned highest digit
// first.
//
// Each slot begins with BLANK_TICKS clocks with every anode off. This guard
// stops the previous digit's pattern from ghosting onto the next digit.
//
// The digit code for a whole frame is sampled into a shadow register at the
// start of the frame. All digits in one frame therefore come from the same
// indata snapshot.
//
// Per-digit blanking, blinking and a 3-bit PWM brightness gate the anode
// enable. These controls are not shadowed.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   indata      4*NUM_DIGITS digit codes, nibble i drives digit i
//   mode        0 = traffic-light glyph decode, 1 = hexadecimal decode
//   blank_mask  1 = digit always dark
//   blink_mask  1 = digit blinks at BLINK_HZ
//   brightness  PWM level, 7 = full on, 0 = 1/8 duty
//   sseg        active-low segments {dp,g,f,e,d,c,b,a}, registered
//   an          active-low anodes, registered, at most one bit low
//   frame_tick  one-cycle pulse after each completed frame
// ---------------------------------------------------------------------------
module sseg_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int REFRESH_HZ  = 75,
    parameter int BLINK_HZ    = 2,
    parameter int BLANK_TICKS = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   indata,
    input  logic                      mode,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic [2:0]                brightness,
    output logic [7:0]                sseg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_tick
);

    localparam int SLOT_TICKS = CLK_FREQ_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int BLINK_HALF = CLK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int SLOT_W     = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_TICKS - 1);
    localparam logic [SLOT_W-1:0]  GUARD_END  = SLOT_W'(BLANK_TICKS);
    localparam logic [IDX_W-1:0]   IDX_TOP    = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SLOT_W-1:0]       r_slot_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [2:0]              r_pwm_cnt;
    logic [BLINK_W-1:0]      r_blink_cnt;
    logic                    r_blink_phase;   // 1 = blinking digits hidden
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [7:0]              r_sseg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_tick;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                    w_slot_end;
    logic                    w_frame_start;
    logic                    w_en;
    logic [3:0]              w_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_sel;           // one-hot, 1 = current digit
    logic [7:0]              w_glyph;

    // Slice the shadow into per-digit nibbles and build the one-hot digit
    // select. Both are indexed later by r_idx.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_nib[gi] = r_shadow[4*gi +: 4];
            assign w_sel[gi] = (r_idx == IDX_W'(gi));
        end
    endgenerate

    assign w_slot_end    = (r_slot_cnt == SLOT_LAST);
    assign w_frame_start = (r_slot_cnt == '0) && (r_idx == IDX_TOP);

    // The guard interval, masks and PWM all gate a single enable.
    // The anode register is therefore either all ones or exactly one low bit.
    assign w_en = (r_slot_cnt >= GUARD_END)
                & ~|(blank_mask & w_sel)
                & ~(|(blink_mask & w_sel) & r_blink_phase)
                & (r_pwm_cnt <= brightness);

    function automatic logic [7:0] f_glyph(input logic [3:0] nib,
                                           input logic       hex_mode);
        logic [7:0] g;
        g = 8'hFF;
        if (hex_mode) begin
            case (nib)
                4'h0: g = 8'hC0;
                4'h1: g = 8'hF9;
                4'h2: g = 8'hA4;
                4'h3: g = 8'hB0;
                4'h4: g = 8'h99;
                4'h5: g = 8'h92;
                4'h6: g = 8'h82;
                4'h7: g = 8'hF8;
                4'h8: g = 8'h80;
                4'h9: g = 8'h90;
                4'hA: g = 8'h88;
                4'hB: g = 8'h83;
                4'hC: g = 8'hC6;
                4'hD: g = 8'hA1;
                4'hE: g = 8'h86;
                default: g = 8'h8E;
            endcase
        end else begin
            // Traffic glyphs: green / yellow / red bars plus left-arrow
            // variants; anything else is dark.
            case (nib)
                4'h0: g = 8'hF7;
                4'h1: g = 8'hBF;
                4'h2: g = 8'hFE;
                4'h3: g = 8'hEE;
                4'h4: g = 8'hDE;
                default: g = 8'hFF;
            endcase
        end
        return g;
    endfunction

    always_comb begin
        w_glyph = f_glyph(w_nib[r_idx], mode);
    end

    // ------------------------------------------------------------------
    // Counters, shadow and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_cnt    <= '0;
            r_idx         <= IDX_TOP;
            r_pwm_cnt     <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_shadow      <= '0;
            r_sseg        <= 8'hFF;
            r_an          <= '1;
            r_frame_tick  <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 3'd1;

            if (w_slot_end) begin
                r_slot_cnt <= '0;
                r_idx      <= (r_idx == '0) ? IDX_TOP : r_idx - IDX_W'(1);
            end else begin
                r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
            end

            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end

            if (w_frame_start) begin
                r_shadow <= indata;
            end

            r_frame_tick <= w_slot_end && (r_idx == '0);

            if (w_en) begin
                r_an   <= ~w_sel;
                r_sseg <= w_glyph;
            end else begin
                r_an   <= '1;
                r_sseg <= 8'hFF;
            end
        end
    end

    assign sseg       = r_sseg;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_sseg_scan_mux
//
// Directed bench for sseg_scan_mux with CLK_FREQ_HZ=800, REFRESH_HZ=10,
// NUM_DIGITS=4, BLANK_TICKS=4 and BLINK_HZ=1. This gives SLOT_TICKS=20 and
// BLINK_HALF=400.
//
// k is the index of the clock edge since reset release; edge 0 is the first
// edge with reset low. The outputs seen after edge k reflect the counter state
// at that edge:
//   slot       = k % 20
//   idx        = 3 - (k/20) % 4
//   pwm        = k % 8
//   hidden     = (k/400) is odd
//   frame_tick = high when k % 80 == 79
// ---------------------------------------------------------------------------
module tb_sseg_scan_mux;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] indata = 16'h0000;
    logic        mode = 1'b0;
    logic [3:0]  blank_mask = 4'b0000;
    logic [3:0]  blink_mask = 4'b0000;
    logic [2:0]  brightness = 3'd7;
    logic [7:0]  sseg;
    logic [3:0]  an;
    logic        frame_tick;

    int n_cmp = 0;
    int n_err = 0;
    int k = 0;
    int lit;

    always #5 clk = ~clk;

    sseg_scan_mux #(
        .NUM_DIGITS  (4),
        .CLK_FREQ_HZ (800),
        .REFRESH_HZ  (10),
        .BLINK_HZ    (1),
        .BLANK_TICKS (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .indata     (indata),
        .mode       (mode),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .brightness (brightness),
        .sseg       (sseg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step n edges and check an/sseg/frame_tick after each one.
    // g3..g0 are the expected glyphs of digits 3..0 for this stretch.
    // lit_o counts the cycles with any anode low.
    task automatic scan_check(input string tag, input int n,
                              input logic [7:0] g3, input logic [7:0] g2,
                              input logic [7:0] g1, input logic [7:0] g0,
                              output int lit_o);
        logic [7:0] g [4];
        g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
        lit_o = 0;
        for (int c = 0; c < n; c++) begin
            int         slot;
            int         idx;
            logic       on;
            logic [3:0] e_an;
            logic [7:0] e_seg;
            slot = k % 20;
            idx  = 3 - ((k / 20) % 4);
            on   = (slot >= 4) && !blank_mask[idx]
                   && !(blink_mask[idx] && ((k / 400) % 2 == 1))
                   && ((k % 8) <= int'(brightness));
            @(posedge clk);
            #1;
            e_an  = on ? ~(4'b0001 << idx) : 4'hF;
            e_seg = on ? g[idx] : 8'hFF;
            chk($sformatf("%s an k=%0d", tag, k), 32'(an), 32'(e_an));
            chk($sformatf("%s sseg k=%0d", tag, k), 32'(sseg), 32'(e_seg));
            chk($sformatf("%s frame_tick k=%0d", tag, k), 32'(frame_tick),
                32'((k % 80) == 79));
            if (an != 4'hF) lit_o++;
            k++;
        end
        $display("step %-14s %4d cycles, now k=%0d, lit cycles=%0d", tag, n, k, lit_o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1. Reset for 3 cycles, then scan traffic glyphs 0/1/2/3
        reset  = 1'b1;
        indata = 16'h0123;
        mode   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("reset an", 32'(an), 32'hF);
            chk("reset sseg", 32'(sseg), 32'hFF);
            chk("reset frame_tick", 32'(frame_tick), 32'h0);
        end
        $display("step reset         3 cycles held");
        reset = 1'b0;
        k = 0;
        scan_check("scan", 160, 8'hF7, 8'hBF, 8'hFE, 8'hEE, lit);
        chk("scan lit count", 32'(lit), 32'd128);

        // 2. Frame coherence: indata changes at cycle 30 of the frame
        scan_check("coh_pre", 30, 8'hF7, 8'hBF, 8'hFE, 8'hEE, lit);
        indata = 16'h4444;
        scan_check("coh_rest", 50, 8'hF7, 8'hBF, 8'hFE, 8'hEE, lit);
        scan_check("coh_next", 80, 8'hDE, 8'hDE, 8'hDE, 8'hDE, lit);

        // 3. Hex decode
        mode   = 1'b1;
        indata = 16'hA5F0;
        scan_check("hex_A5F0", 80, 8'h88, 8'h92, 8'h8E, 8'hC0, lit);
        indata = 16'h6789;
        scan_check("hex_6789", 80, 8'h82, 8'hF8, 8'h80, 8'h90, lit);

        // 4. Blank digit 1, blink digit 3 (k=480..799 hidden, 800..1199 visible)
        mode       = 1'b0;
        indata     = 16'h0123;
        blank_mask = 4'b0010;
        blink_mask = 4'b1000;
        scan_check("blink_hidden", 320, 8'hF7, 8'hBF, 8'hFE, 8'hEE, lit);
        chk("blink hidden lit count", 32'(lit), 32'd128);
        scan_check("blink_shown", 400, 8'hF7, 8'hBF, 8'hFE, 8'hEE, lit);
        chk("blink shown lit count", 32'(lit), 32'd240);
        scan_check("blink_hidden2", 80, 8'hF7, 8'hBF, 8'hFE, 8'hEE, lit);
        chk("blink hidden2 lit count", 32'(lit), 32'd32);

        // 5. Brightness
        blank_mask = 4'b0000;
        blink_mask = 4'b0000;
        brightness = 3'd0;
        scan_check("bright0", 20, 8'hF7, 8'hBF, 8'hFE, 8'hEE, lit);
        chk("bright0 lit count", 32'(lit), 32'd2);
        brightness = 3'd3;
        scan_check("bright3", 20, 8'hF7, 8'hBF, 8'hFE, 8'hEE, lit);
        chk("bright3 lit count", 32'(lit), 32'd8);
        scan_check("bright3_run", 40, 8'hF7, 8'hBF, 8'hFE, 8'hEE, lit);

        // 6. Reset at slot_cnt=10, idx=2, with new data presented meanwhile
        brightness = 3'd7;
        scan_check("pre_reset", 30, 8'hF7, 8'hBF, 8'hFE, 8'hEE, lit);
        chk("pre_reset lit count", 32'(lit), 32'd22);
        reset  = 1'b1;
        indata = 16'h4321;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk("midreset an", 32'(an), 32'hF);
            chk("midreset sseg", 32'(sseg), 32'hFF);
            chk("midreset frame_tick", 32'(frame_tick), 32'h0);
        end
        $display("step midreset      2 cycles held");
        reset = 1'b0;
        k = 0;
        scan_check("after_reset", 80, 8'hDE, 8'hEE, 8'hFE, 8'hBF, lit);
        chk("after_reset lit count", 32'(lit), 32'd64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
